// File: rtl/wb_bringup_master_if.sv
// Command, response and Wishbone initiator signals of wb_bringup_master.
// master: the initiator's view; slave: the view of the harness/responder around it.
interface wb_bringup_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_dat_i, wbm_ack_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_dat_i, wbm_ack_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_bringup_master.sv
// Single-beat Wishbone classic initiator for bring-up harnesses; all outputs registered.
// Optional ack watchdog enabled by defining WB_BRINGUP_MASTER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a command (cmd_ready high from the second IDLE cycle)
// BUS   | cyc/stb asserted, waiting for wbm_ack_i (or watchdog expiry)
// RESP  | response presented, waiting for rsp_ready
module wb_bringup_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_bringup_master_if.master bus,
  output logic                busy,
  output logic [CNT_W-1:0]    txn_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  state_t             state, state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic [31:0]        rsp_dat_q, rsp_dat_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

`ifdef WB_BRINGUP_MASTER_TIMEOUT_EN
  localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic               rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d     = state;
    cmd_ready_d = 1'b0;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_valid_d = rsp_valid_q;
    cnt_d       = cnt_q;
`ifdef WB_BRINGUP_MASTER_TIMEOUT_EN
    wdog_d      = wdog_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state)
      IDLE: begin
        // cmd_ready is registered, so it rises one cycle after IDLE is entered
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d     = BUS;
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          we_d        = bus.cmd_we;
          sel_d       = bus.cmd_sel;
          adr_d       = bus.cmd_adr;
          dat_d       = bus.cmd_dat;
`ifdef WB_BRINGUP_MASTER_TIMEOUT_EN
          wdog_d      = '0;
`endif
        end
      end
      BUS: begin
        if (bus.wbm_ack_i) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? 32'h0 : bus.wbm_dat_i;
          rsp_valid_d = 1'b1;
`ifdef WB_BRINGUP_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_dat_d   = 32'hDEAD_BEEF;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          wdog_d      = wdog_q + 1'b1;
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cnt_d       = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= 32'h0;
      dat_q       <= 32'h0;
      rsp_dat_q   <= 32'h0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
`ifdef WB_BRINGUP_MASTER_TIMEOUT_EN
      wdog_q      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q       <= cnt_d;
`ifdef WB_BRINGUP_MASTER_TIMEOUT_EN
      wdog_q      <= wdog_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_dat_q;
`ifdef WB_BRINGUP_MASTER_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif
  assign busy          = (state != IDLE);
  assign txn_count     = cnt_q;

endmodule

// File: tb/tb_wb_bringup_master.sv
// Self-checking bench for wb_bringup_master: directed scenarios plus randomized traffic
// against a memory-backed responder model.
module tb_wb_bringup_master;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy;
  logic [15:0] txn_count;

  wb_bringup_master_if bus();

  wb_bringup_master #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .busy     (busy),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mem [logic [31:0]];
  logic [15:0] exp_cnt = 16'h0;
  logic [31:0] last_rsp = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] t;
    t = mem_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) t[8*b +: 8] = d[8*b +: 8];
    mem[a] = t;
  endtask

  // Waits (bounded) for cmd_ready, presents one command, returns at the negedge after acceptance.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    int guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_ready_wait", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    bus.cmd_sel   = sel;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int wait_n, input int hold_n,
                         input bit stray, input bit pend);
    logic [31:0] rdv, exp_rsp;
    rdv = mem_rd(adr);
    issue(we, adr, dat, sel);
    // command inputs are don't-care while the master is busy
    bus.cmd_valid = 1'($urandom);
    bus.cmd_we    = 1'($urandom);
    bus.cmd_adr   = $urandom;
    bus.cmd_dat   = $urandom;
    bus.cmd_sel   = 4'($urandom);
    for (int i = 0; i <= wait_n; i++) begin
      chk("bus_ctl", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.cmd_ready, busy},
          {1'b1, 1'b1, we, sel, 1'b0, 1'b1});
      chk("bus_adr", bus.wbm_adr_o, adr);
      chk("bus_dat", bus.wbm_dat_o, dat);
      if (i == wait_n) begin
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = we ? $urandom : rdv;
      end
      @(negedge clk);
      bus.wbm_ack_i = 1'b0;
    end
    if (we) mem_wr(adr, dat, sel);
    exp_rsp = we ? 32'h0 : rdv;
    for (int i = 0; i <= hold_n; i++) begin
      chk("rsp_ctl", {bus.rsp_valid, bus.rsp_err, bus.wbm_cyc_o, bus.wbm_stb_o, bus.cmd_ready, busy},
          6'b10_0001);
      chk("rsp_dat", bus.rsp_dat, exp_rsp);
      chk("adr_hold", bus.wbm_adr_o, adr);
      if (i == 0 && pend) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b1;
        bus.cmd_adr   = 32'h3000_0008;
        bus.cmd_dat   = 32'h1122_3344;
        bus.cmd_sel   = 4'h3;
      end
      if (i == hold_n) bus.rsp_ready = 1'b1;
      else if (stray && i == 0) begin
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = $urandom;
      end
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.wbm_ack_i = 1'b0;
    end
    if (!pend) bus.cmd_valid = 1'b0;
    exp_cnt++;
    last_rsp = exp_rsp;
    chk("post_hs_ctl", {bus.rsp_valid, busy, bus.cmd_ready, bus.wbm_cyc_o}, 4'b0000);
    chk("txn_count", txn_count, exp_cnt);
    chk("rsp_dat_keep", bus.rsp_dat, last_rsp);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int rises [$];
    logic prev_cyc;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = 32'h0; bus.cmd_dat = 32'h0;
    bus.cmd_sel = 4'h0; bus.rsp_ready = 1'b0; bus.wbm_dat_i = 32'h0; bus.wbm_ack_i = 1'b0;

    // reset
    #1 rst = 1'b1;
    #1;
    chk("rst_ctl", {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.wbm_cyc_o, bus.wbm_stb_o,
                    bus.wbm_we_o, bus.wbm_sel_o, busy}, 0);
    chk("rst_adr", bus.wbm_adr_o, 0);
    chk("rst_wdat", bus.wbm_dat_o, 0);
    chk("rst_rdat", bus.rsp_dat, 0);
    chk("rst_cnt", txn_count, 0);
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", bus.cmd_ready, 1);

    // directed: write, zero-wait ack
    run_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 0, 1'b0, 1'b0);
    // directed: read with 5-cycle cyc
    mem[32'h3000_0000] = 32'hCAFE_F00D;
    run_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 4, 0, 1'b0, 1'b0);
    // directed: 10-cycle backpressure, stray ack in RESP, new command pending
    run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1, 10, 1'b1, 1'b1);
    @(negedge clk);
    chk("pend_not_yet", {bus.cmd_ready, bus.wbm_cyc_o, busy}, 3'b100);
    run_txn(1'b1, 32'h3000_0008, 32'h1122_3344, 4'h3, 0, 1, 1'b0, 1'b0);

    // stray ack in IDLE
    @(negedge clk);
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = $urandom;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    chk("stray_idle_ctl", {busy, bus.wbm_cyc_o, bus.rsp_valid, bus.cmd_ready}, 4'b0001);
    chk("stray_idle_dat", bus.rsp_dat, last_rsp);
    chk("stray_idle_cnt", txn_count, exp_cnt);

    // throughput with rsp_ready high and a zero-wait responder
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_adr = 32'h3000_0010;
    bus.cmd_dat = 32'h0BAD_F00D; bus.cmd_sel = 4'hF;
    prev_cyc = 1'b0;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      if (bus.wbm_cyc_o && !prev_cyc) rises.push_back(i);
      prev_cyc = bus.wbm_cyc_o;
      bus.wbm_ack_i = bus.wbm_cyc_o;
      if (i == 19) bus.cmd_valid = 1'b0;
    end
    bus.wbm_ack_i = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("thru_enough", 32'(rises.size() >= 4), 1);
    for (int k = 1; k < rises.size(); k++) chk("thru_interval", rises[k] - rises[k-1], 4);
    exp_cnt += 16'(rises.size());
    if (rises.size() > 0) mem_wr(32'h3000_0010, 32'h0BAD_F00D, 4'hF);
    chk("thru_cnt", txn_count, exp_cnt);

    // randomized traffic over a small address pool
    for (int t = 0; t < 24; t++) begin
      int hold;
      hold = $urandom_range(0, 3);
      run_txn(1'($urandom), 32'h3000_0000 + 32'(4 * $urandom_range(0, 4)), $urandom,
              4'($urandom), $urandom_range(0, 5), hold, (hold > 0) && 1'($urandom), 1'b0);
    end

`ifdef WB_BRINGUP_MASTER_TIMEOUT_EN
    // ack on the expiry edge wins
    run_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, TO - 1, 0, 1'b0, 1'b0);
    // no ack: abort after TO bus cycles
    issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    n = 0;
    while (bus.wbm_cyc_o === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("to_cycles", n, TO);
    chk("to_ctl", {bus.rsp_valid, bus.rsp_err}, 2'b11);
    chk("to_dat", bus.rsp_dat, 32'hDEAD_BEEF);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_cnt++;
    last_rsp = 32'hDEAD_BEEF;
    chk("to_cnt", txn_count, exp_cnt);
`else
    // no watchdog: cyc stays high while the responder never acks
    issue(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.wbm_cyc_o === 1'b1 && bus.rsp_valid === 1'b0) n++;
      @(negedge clk);
    end
    chk("no_to_cycles", n, 1000);
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = mem_rd(32'h3000_0004);
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    chk("no_to_rsp", {bus.rsp_valid, bus.rsp_err, bus.wbm_cyc_o}, 3'b100);
    chk("no_to_dat", bus.rsp_dat, mem_rd(32'h3000_0004));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_cnt++;
    chk("no_to_cnt", txn_count, exp_cnt);
`endif

    // reset asserted between edges during BUS
    chk("pre_rst_cnt_nonzero", 32'(txn_count != 16'h0), 1);
    issue(1'b1, 32'h3000_0000, 32'hFFFF_FFFF, 4'hF);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_ctl", {bus.wbm_cyc_o, bus.wbm_stb_o, busy, bus.rsp_valid, bus.cmd_ready}, 0);
    chk("mid_rst_cnt", txn_count, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'h0;
    @(negedge clk);
    chk("post_rst_ready", bus.cmd_ready, 1);
    run_txn(1'b1, 32'h3000_000C, 32'h5555_AAAA, 4'hF, 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 2, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
